// File: rtl/aes_core_ctrl_if.sv
// aes_core_ctrl_if: request/response handshake bundle between a host (master) and aes_core_ctrl (slave)
//   req_*: valid/ready request carrying mode (0 enc, 1 dec), 128-bit key and text
//   rsp_*: valid/ready response carrying result text, originating mode and watchdog error flag
interface aes_core_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_mode;
  logic [127:0] req_key;
  logic [127:0] req_text;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_text;
  logic         rsp_mode;
  logic         rsp_err;
  modport master (
    output req_valid, req_mode, req_key, req_text, rsp_ready,
    input  req_ready, rsp_valid, rsp_text, rsp_mode, rsp_err
  );
  modport slave (
    input  req_valid, req_mode, req_key, req_text, rsp_ready,
    output req_ready, rsp_valid, rsp_text, rsp_mode, rsp_err
  );
endinterface

// File: rtl/aes_core_ctrl.sv
// aes_core_ctrl: schedules one request at a time onto a shared encrypt core and decrypt core
//   clk, rst     : clock and asynchronous active-high reset
//   bus          : request/response handshake (slave side)
//   core_key/text: operands presented to both cores, held from acceptance to next acceptance
//   enc_ld       : encrypt start pulse; enc_done/enc_text: encrypt result
//   dec_kld      : decrypt key-expansion start pulse; dec_kdone: key schedule ready
//   dec_ld       : decrypt start pulse; dec_done/dec_text: decrypt result
module aes_core_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  aes_core_ctrl_if.slave bus,
  output logic [127:0]  core_key,
  output logic [127:0]  core_text,
  output logic          enc_ld,
  input  logic          enc_done,
  input  logic [127:0]  enc_text,
  output logic          dec_kld,
  input  logic          dec_kdone,
  output logic          dec_ld,
  input  logic          dec_done,
  input  logic [127:0]  dec_text
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] WD_MAX = W'(TIMEOUT);
  localparam logic [2:0] IDLE = 3'd0, KEXP = 3'd1, ENC_RUN = 3'd2, DEC_RUN = 3'd3, RESP = 3'd4;
  logic [2:0]   state_q, state_d;
  logic [W-1:0] wd_q, wd_d;
  logic [127:0] key_q, key_d, text_q, text_d, rtext_q, rtext_d, kcache_q, kcache_d;
  logic         mode_q, mode_d, err_q, err_d, kvalid_q, kvalid_d;
  logic         enc_ld_q, enc_ld_d, dec_kld_q, dec_kld_d, dec_ld_q, dec_ld_d;
  logic         run, hit, core_done;
  always_comb begin
    run       = state_q == KEXP || state_q == ENC_RUN || state_q == DEC_RUN;
    hit       = kvalid_q && bus.req_key == kcache_q;
    core_done = state_q == ENC_RUN ? enc_done : state_q == DEC_RUN && dec_done;
    state_d   = state_q;
    key_d     = key_q;
    text_d    = text_q;
    rtext_d   = rtext_q;
    kcache_d  = kcache_q;
    mode_d    = mode_q;
    err_d     = err_q;
    kvalid_d  = kvalid_q;
    enc_ld_d  = 1'b0;
    dec_kld_d = 1'b0;
    dec_ld_d  = 1'b0;
    if (state_q == IDLE && bus.req_valid) begin
      key_d     = bus.req_key;
      text_d    = bus.req_text;
      mode_d    = bus.req_mode;
      state_d   = !bus.req_mode ? ENC_RUN : hit ? DEC_RUN : KEXP;
      enc_ld_d  = !bus.req_mode;
      dec_ld_d  = bus.req_mode && hit;
      dec_kld_d = bus.req_mode && !hit;
      kvalid_d  = kvalid_q && !(bus.req_mode && !hit);
    end else if (state_q == KEXP && dec_kdone) begin
      kcache_d = key_q;
      kvalid_d = 1'b1;
      state_d  = DEC_RUN;
      dec_ld_d = 1'b1;
    end else if (core_done) begin
      // checked before the watchdog so a done on the timeout cycle still wins
      rtext_d = state_q == ENC_RUN ? enc_text : dec_text;
      err_d   = 1'b0;
      state_d = RESP;
    end else if (run && wd_q == WD_MAX) begin
      rtext_d  = '0;
      err_d    = 1'b1;
      kvalid_d = 1'b0;
      state_d  = RESP;
    end else if (state_q == RESP && bus.rsp_ready) begin
      state_d = IDLE;
    end
    // any state change (including KEXP -> DEC_RUN) restarts the count
    wd_d = run && state_d == state_q ? wd_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wd_q      <= '0;
      key_q     <= '0;
      text_q    <= '0;
      rtext_q   <= '0;
      kcache_q  <= '0;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      kvalid_q  <= 1'b0;
      enc_ld_q  <= 1'b0;
      dec_kld_q <= 1'b0;
      dec_ld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      key_q     <= key_d;
      text_q    <= text_d;
      rtext_q   <= rtext_d;
      kcache_q  <= kcache_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      kvalid_q  <= kvalid_d;
      enc_ld_q  <= enc_ld_d;
      dec_kld_q <= dec_kld_d;
      dec_ld_q  <= dec_ld_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_text  = rtext_q;
  assign bus.rsp_mode  = mode_q;
  assign bus.rsp_err   = err_q;
  assign core_key      = key_q;
  assign core_text     = text_q;
  assign enc_ld        = enc_ld_q;
  assign dec_kld       = dec_kld_q;
  assign dec_ld        = dec_ld_q;
endmodule

// File: tb/tb_aes_core_ctrl.sv
// tb_aes_core_ctrl: directed scoreboard bench for aes_core_ctrl with behavioural core responders
module tb_aes_core_ctrl;
  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  typedef struct packed { logic [127:0] t; logic m; logic e; } rsp_t;
  logic clk, rst;
  logic [127:0] core_key, core_text, enc_text, dec_text, enc_val, dec_val, cap;
  logic enc_ld, enc_done, dec_kld, dec_kdone, dec_ld, dec_done;
  logic enc_done_m, dec_kdone_m, dec_done_m, spur, enc_hang, dec_hang;
  logic prev_rv, prev_e, prev_k, prev_l;
  int n_cmp, n_bad, n_rsp, ncyc, enc_cyc, ld_cyc, kd_cyc, done_cyc, rv_cyc, excl, dbl, bp_bad, saved;
  rsp_t sbq[$];
  rsp_t ex;
  aes_core_ctrl_if bus();
  assign enc_done  = enc_done_m | spur;
  assign dec_kdone = dec_kdone_m | spur;
  assign dec_done  = dec_done_m | spur;
  aes_core_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .core_key(core_key), .core_text(core_text),
    .enc_ld(enc_ld), .enc_done(enc_done), .enc_text(enc_text),
    .dec_kld(dec_kld), .dec_kdone(dec_kdone), .dec_ld(dec_ld),
    .dec_done(dec_done), .dec_text(dec_text)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask
  // encrypt: done 3 edges after the pulse; key expansion: 4 edges; decrypt: 3 edges
  initial begin
    enc_done_m = 0; dec_kdone_m = 0; dec_done_m = 0; enc_text = '0; dec_text = '0;
    forever begin
      @(negedge clk);
      if (enc_ld && !enc_hang) begin
        repeat (3) @(posedge clk);
        #1 enc_text = enc_val; enc_done_m = 1;
        @(posedge clk);
        #1 enc_done_m = 0;
      end else if (dec_kld) begin
        repeat (4) @(posedge clk);
        #1 dec_kdone_m = 1;
        @(posedge clk);
        #1 dec_kdone_m = 0;
      end else if (dec_ld && !dec_hang) begin
        repeat (3) @(posedge clk);
        #1 dec_text = dec_val; dec_done_m = 1;
        @(posedge clk);
        #1 dec_done_m = 0;
      end
    end
  end
  initial begin
    ncyc = 0; prev_rv = 0; prev_e = 0; prev_k = 0; prev_l = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (enc_ld) enc_cyc = ncyc;
      if (dec_ld) ld_cyc = ncyc;
      if (dec_kdone) kd_cyc = ncyc;
      if (enc_done || dec_done) done_cyc = ncyc;
      if (bus.rsp_valid && !prev_rv) rv_cyc = ncyc;
      if (32'(enc_ld) + 32'(dec_kld) + 32'(dec_ld) > 1) excl++;
      if ((enc_ld && prev_e) || (dec_kld && prev_k) || (dec_ld && prev_l)) dbl++;
      prev_rv = bus.rsp_valid; prev_e = enc_ld; prev_k = dec_kld; prev_l = dec_ld;
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: actual text %h err %b, required no response", bus.rsp_text, bus.rsp_err);
        end else begin
          ex = sbq.pop_front();
          chk("rsp_text", bus.rsp_text, ex.t);
          chk("rsp_mode", 128'(bus.rsp_mode), 128'(ex.m));
          chk("rsp_err", 128'(bus.rsp_err), 128'(ex.e));
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: actual still running, required finish");
    $fatal(1);
  end
  task automatic send(input logic m, input logic [127:0] k, input logic [127:0] t);
    bus.req_mode = m; bus.req_key = k; bus.req_text = t; bus.req_valid = 1;
    for (int i = 0; i < 300 && !bus.req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1 bus.req_valid = 0;
  endtask
  task automatic wait_idle(input string nm);
    for (int i = 0; i < 300 && !bus.req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    chk(nm, 128'(bus.req_ready), 128'(1'b1));
  endtask
  initial begin
    n_cmp = 0; n_bad = 0; n_rsp = 0; excl = 0; dbl = 0; bp_bad = 0;
    enc_cyc = 0; ld_cyc = 0; kd_cyc = 0; done_cyc = 0; rv_cyc = 0;
    rst = 1; spur = 0; enc_hang = 0; dec_hang = 0; enc_val = '0; dec_val = '0;
    bus.req_valid = 0; bus.req_mode = 0; bus.req_key = '0; bus.req_text = '0; bus.rsp_ready = 1;
    #1;
    chk("rst req_ready", 128'(bus.req_ready), 128'(1'b1));
    chk("rst rsp_valid", 128'(bus.rsp_valid), 128'(1'b0));
    chk("rst rsp_err", 128'(bus.rsp_err), 128'(1'b0));
    chk("rst rsp_mode", 128'(bus.rsp_mode), 128'(1'b0));
    chk("rst rsp_text", bus.rsp_text, '0);
    chk("rst core_key", core_key, '0);
    chk("rst core_text", core_text, '0);
    chk("rst pulses", 128'({enc_ld, dec_kld, dec_ld}), '0);
    @(posedge clk);
    #1 rst = 0;
    // FIPS-197 C.1 encrypt
    enc_val = CT;
    sbq.push_back({CT, 1'b0, 1'b0});
    send(0, K, PT);
    chk("enc enc_ld c1", 128'(enc_ld), 128'(1'b1));
    chk("enc core_key", core_key, K);
    chk("enc core_text", core_text, PT);
    wait_idle("enc idle");
    chk("enc done->valid", 128'(rv_cyc - done_cyc), 128'(1));
    // decrypt, cache miss
    dec_val = PT;
    sbq.push_back({PT, 1'b1, 1'b0});
    send(1, K, CT);
    chk("dec miss kld", 128'({dec_kld, dec_ld}), 128'(2'b10));
    wait_idle("dec miss idle");
    chk("dec kdone->ld", 128'(ld_cyc - kd_cyc), 128'(1));
    // decrypt, cache hit
    sbq.push_back({PT, 1'b1, 1'b0});
    send(1, K, CT);
    chk("dec hit ld c1", 128'({dec_kld, dec_ld}), 128'(2'b01));
    wait_idle("dec hit idle");
    // new key forces re-expansion
    dec_val = 128'hfedcba98765432100123456789abcdef;
    sbq.push_back({dec_val, 1'b1, 1'b0});
    send(1, K + 1, CT);
    chk("dec key+1 kld", 128'({dec_kld, dec_ld}), 128'(2'b10));
    wait_idle("dec key+1 idle");
    // backpressure with next request held pending
    bus.rsp_ready = 0;
    enc_val = 128'h0f0e0d0c0b0a09080706050403020100;
    sbq.push_back({enc_val, 1'b0, 1'b0});
    send(0, K, PT);
    bus.req_mode = 0; bus.req_key = K; bus.req_text = CT; bus.req_valid = 1;
    for (int i = 0; i < 100 && !bus.rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    cap = bus.rsp_text;
    enc_val = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!bus.rsp_valid || bus.rsp_text !== cap || bus.req_ready) bp_bad++;
    end
    chk("bp stable", 128'(bp_bad), '0);
    chk("bp held text", cap, 128'h0f0e0d0c0b0a09080706050403020100);
    sbq.push_back({enc_val, 1'b0, 1'b0});
    bus.rsp_ready = 1;
    @(posedge clk);
    #1;
    chk("bp no early accept", 128'({bus.req_ready, enc_ld}), 128'(2'b10));
    @(posedge clk);
    #1 bus.req_valid = 0;
    chk("bp accept after hs", 128'(enc_ld), 128'(1'b1));
    wait_idle("bp idle");
    // watchdog: encrypt core never finishes
    enc_hang = 1;
    sbq.push_back({128'h0, 1'b0, 1'b1});
    send(0, K, PT);
    wait_idle("wdog idle");
    enc_hang = 0;
    chk("wdog latency", 128'(rv_cyc - enc_cyc), 128'(17));
    send(1, K + 1, CT);
    chk("wdog re-expand", 128'({dec_kld, dec_ld}), 128'(2'b10));
    sbq.push_back({dec_val, 1'b1, 1'b0});
    wait_idle("wdog dec idle");
    // spurious dones while idle
    @(posedge clk);
    #1 spur = 1;
    @(posedge clk);
    #1 spur = 0;
    chk("spurious ignored", 128'({bus.req_ready, bus.rsp_valid}), 128'(2'b10));
    // reset during DEC_RUN
    dec_hang = 1;
    send(1, K + 1, CT);
    chk("rst-test dec hit", 128'(dec_ld), 128'(1'b1));
    saved = n_rsp;
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("mid rst req_ready", 128'(bus.req_ready), 128'(1'b1));
    chk("mid rst outputs", 128'({bus.rsp_valid, bus.rsp_err, enc_ld, dec_kld, dec_ld}), '0);
    chk("mid rst core_key", core_key, '0);
    @(posedge clk);
    #1 rst = 0; dec_hang = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("no rsp after rst", 128'(n_rsp), 128'(saved));
    sbq.push_back({dec_val, 1'b1, 1'b0});
    send(1, K + 1, CT);
    chk("post rst kld", 128'({dec_kld, dec_ld}), 128'(2'b10));
    wait_idle("post rst idle");
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", 128'(sbq.size()), '0);
    chk("pulse exclusive", 128'(excl), '0);
    chk("pulse single cycle", 128'(dbl), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
